// File: rtl/image_buffer_ram.sv
// Row-major frame buffer RAM with pipelined reads, bounds checking and
// a full-frame clear sequencer.
module image_buffer_ram #(
   parameter int    IMG_W     = 256,
   parameter int    IMG_H     = 256,
   parameter int    PIX_W     = 8,
   parameter int    OUT_REG   = 1,
   parameter string INIT_FILE = "",
   localparam int   DEPTH     = IMG_W * IMG_H,
   localparam int   XW        = $clog2(IMG_W),
   localparam int   YW        = $clog2(IMG_H),
   localparam int   AW        = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [XW-1:0]    wr_x,
   input  logic [YW-1:0]    wr_y,
   input  logic [PIX_W-1:0] wr_data,
   input  logic             rd_en,
   input  logic [XW-1:0]    rd_x,
   input  logic [YW-1:0]    rd_y,
   output logic [PIX_W-1:0] rd_data,
   output logic             rd_valid,
   input  logic             clr_start,
   output logic             clr_busy,
   output logic             oob_err
);

   typedef enum logic {IDLE, CLEAR} state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic [PIX_W-1:0] mem [DEPTH];

   logic             wr_inb, rd_inb, idle;
   logic             rd_acc, oob_hit;
   logic [AW-1:0]    wr_addr, rd_addr;
   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [PIX_W-1:0] mem_wdata;

   logic             s0_v_q;
   logic [PIX_W-1:0] s0_d_q;
   logic             last_v;
   logic [PIX_W-1:0] last_d;
   logic             rd_valid_q;
   logic [PIX_W-1:0] rd_data_q;
   logic             oob_q;

   assign wr_inb  = (32'(wr_x) < IMG_W) && (32'(wr_y) < IMG_H);
   assign rd_inb  = (32'(rd_x) < IMG_W) && (32'(rd_y) < IMG_H);
   assign wr_addr = AW'(32'(wr_y) * IMG_W + 32'(wr_x));
   assign rd_addr = AW'(32'(rd_y) * IMG_W + 32'(rd_x));
   assign idle    = (state_q == IDLE);
   assign rd_acc  = idle && rd_en && rd_inb;
   assign oob_hit = idle && ((wr_en && !wr_inb) || (rd_en && !rd_inb));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_we    = 1'b0;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
      unique case (state_q)
         IDLE: begin
            mem_we = wr_en && wr_inb;
            if (clr_start) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
            if (cnt_q == AW'(DEPTH - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         oob_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (oob_hit) oob_q <= 1'b1;
      end
   end

   // Memory is deliberately outside reset so an aborted clear leaves data.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_v_q <= 1'b0;
         s0_d_q <= '0;
      end else begin
         s0_v_q <= rd_acc;
         if (rd_acc) s0_d_q <= mem[rd_addr];
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic             s1_v_q;
         logic [PIX_W-1:0] s1_d_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s1_v_q <= 1'b0;
               s1_d_q <= '0;
            end else begin
               s1_v_q <= s0_v_q;
               if (s0_v_q) s1_d_q <= s0_d_q;
            end
         end
         assign last_v = s1_v_q;
         assign last_d = s1_d_q;
      end else begin : g_noreg
         assign last_v = s0_v_q;
         assign last_d = s0_d_q;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= last_v;
         if (last_v) rd_data_q <= last_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign clr_busy = (state_q == CLEAR);
   assign oob_err  = oob_q;

endmodule

// File: tb/tb_image_buffer_ram.sv
// Scoreboard bench: three buffer instances (4x4 registered, 4x4 direct,
// 3x4 registered) driven with directed vectors.
module tb_image_buffer_ram;

   localparam int NU = 3;

   typedef struct {
      logic [7:0] d;
      int         due;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en    [NU];
   logic       rd_en    [NU];
   logic       clr      [NU];
   logic [1:0] wr_x     [NU];
   logic [1:0] wr_y     [NU];
   logic [1:0] rd_x     [NU];
   logic [1:0] rd_y     [NU];
   logic [7:0] wr_data  [NU];
   logic [7:0] rd_data  [NU];
   logic       rd_valid [NU];
   logic       clr_busy [NU];
   logic       oob_err  [NU];

   exp_t exp_q [NU][$];
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NU; g++) begin : g_dut
      image_buffer_ram #(
         .IMG_W   (g == 2 ? 3 : 4),
         .IMG_H   (4),
         .PIX_W   (8),
         .OUT_REG (g == 1 ? 0 : 1)
      ) dut (
         .clk       (clk),
         .rst       (rst),
         .wr_en     (wr_en[g]),
         .wr_x      (wr_x[g]),
         .wr_y      (wr_y[g]),
         .wr_data   (wr_data[g]),
         .rd_en     (rd_en[g]),
         .rd_x      (rd_x[g]),
         .rd_y      (rd_y[g]),
         .rd_data   (rd_data[g]),
         .rd_valid  (rd_valid[g]),
         .clr_start (clr[g]),
         .clr_busy  (clr_busy[g]),
         .oob_err   (oob_err[g])
      );
   end

   function automatic int oreg(int u);
      return (u == 1) ? 0 : 1;
   endfunction

   task automatic chk(string nm, int u, logic [7:0] act, logic [7:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %0h want %0h", nm, u, act, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int u = 0; u < NU; u++) begin
         wr_en[u] = 1'b0;
         rd_en[u] = 1'b0;
         clr[u]   = 1'b0;
      end
   endtask

   task automatic wr(int u, int x, int y, logic [7:0] d);
      wr_en[u]   = 1'b1;
      wr_x[u]    = 2'(x);
      wr_y[u]    = 2'(y);
      wr_data[u] = d;
   endtask

   task automatic rdx(int u, int x, int y);
      rd_en[u] = 1'b1;
      rd_x[u]  = 2'(x);
      rd_y[u]  = 2'(y);
   endtask

   task automatic rd(int u, int x, int y, logic [7:0] e);
      exp_t t;
      rdx(u, x, y);
      t.d   = e;
      t.due = cyc + 2 + oreg(u);
      exp_q[u].push_back(t);
   endtask

   // Monitor: pops one expectation per rd_valid pulse and checks timing.
   always @(negedge clk) begin
      exp_t e;
      for (int u = 0; u < NU; u++) begin
         if (rd_valid[u]) begin
            n_cmp++;
            if (exp_q[u].size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_valid[%0d]: got data %0h at cyc %0d want no read",
                        u, rd_data[u], cyc);
            end else begin
               e = exp_q[u].pop_front();
               if (rd_data[u] !== e.d || cyc != e.due) begin
                  n_bad++;
                  $display("FAIL rd_data[%0d]: got %0h at cyc %0d want %0h at cyc %0d",
                           u, rd_data[u], cyc, e.d, e.due);
               end
            end
         end
         while (exp_q[u].size() > 0 && exp_q[u][0].due <= cyc) begin
            e = exp_q[u].pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_valid[%0d]: got no rd_valid want %0h at cyc %0d",
                     u, e.d, e.due);
         end
      end
   end

   initial begin
      int n;
      for (int u = 0; u < NU; u++) begin
         wr_en[u] = 0; rd_en[u] = 0; clr[u] = 0;
         wr_x[u] = 0; wr_y[u] = 0; rd_x[u] = 0; rd_y[u] = 0;
         wr_data[u] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < NU; u++) begin
         chk("rst_rd_valid", u, 8'(rd_valid[u]), 8'h00);
         chk("rst_rd_data",  u, rd_data[u], 8'h00);
         chk("rst_clr_busy", u, 8'(clr_busy[u]), 8'h00);
         chk("rst_oob_err",  u, 8'(oob_err[u]), 8'h00);
      end
      rst = 1'b0;

      // 4x4, registered output: basic write/read, RAW same cycle, burst
      wr(0, 1, 2, 8'hA5); step();
      rd(0, 1, 2, 8'hA5); step();
      wr(0, 0, 0, 8'h22); step();
      wr(0, 0, 0, 8'h11); rd(0, 0, 0, 8'h22); step();
      rd(0, 0, 0, 8'h11); step();
      wr(0, 3, 3, 8'h33); step();
      wr(0, 2, 1, 8'h21); step();
      rd(0, 3, 3, 8'h33); step();
      rd(0, 0, 0, 8'h11); step();
      rd(0, 2, 1, 8'h21); step();

      // 4x4, unregistered output: burst and hold
      wr(1, 3, 3, 8'hC3); step();
      wr(1, 0, 0, 8'h0F); step();
      wr(1, 2, 1, 8'h6D); step();
      rd(1, 3, 3, 8'hC3); step();
      rd(1, 0, 0, 8'h0F); step();
      rd(1, 2, 1, 8'h6D); step();
      repeat (4) step();
      chk("hold_valid", 1, 8'(rd_valid[1]), 8'h00);
      chk("hold_data",  1, rd_data[1], 8'h6D);

      // 3x4: out-of-bounds column aliases address 3 = (0,1) if not dropped
      wr(2, 0, 1, 8'h77); step();
      wr(2, 2, 3, 8'h5A); step();
      chk("oob_clean", 2, 8'(oob_err[2]), 8'h00);
      wr(2, 3, 0, 8'hFF); step();
      chk("oob_set", 2, 8'(oob_err[2]), 8'h01);
      rdx(2, 3, 1); step();
      rd(2, 0, 1, 8'h77); step();
      rd(2, 2, 3, 8'h5A); step();
      repeat (4) step();
      chk("oob_held", 2, 8'(oob_err[2]), 8'h01);

      // full clear on instance 0
      for (int i = 0; i < 16; i++) begin
         wr(0, i % 4, i / 4, 8'(i + 1)); step();
      end
      clr[0] = 1'b1;
      rd(0, 1, 0, 8'h02);
      step();
      n = 0;
      for (int i = 0; i < 24; i++) begin
         if (clr_busy[0]) n++;
         if (i == 3) begin
            wr(0, 0, 0, 8'hEE);
            rdx(0, 2, 2);
         end
         if (i == 5) clr[0] = 1'b1;
         step();
      end
      chk("clr_cycles", 0, 8'(n), 8'd16);
      for (int i = 0; i < 16; i++) begin
         rd(0, i % 4, i / 4, 8'h00); step();
      end
      repeat (4) step();

      // reset aborts a clear on instance 1 after addresses 0..4
      for (int i = 0; i < 16; i++) begin
         wr(1, i % 4, i / 4, 8'(8'h80 + i)); step();
      end
      clr[1] = 1'b1; step();
      chk("clr_busy_on", 1, 8'(clr_busy[1]), 8'h01);
      repeat (5) step();
      rst = 1'b1;
      #1;
      chk("abort_busy",  1, 8'(clr_busy[1]), 8'h00);
      chk("abort_valid", 1, 8'(rd_valid[1]), 8'h00);
      chk("abort_oob",   2, 8'(oob_err[2]), 8'h00);
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i != 5) begin
            rd(1, i % 4, i / 4, (i < 5) ? 8'h00 : 8'(8'h80 + i));
            step();
         end
      end
      repeat (6) step();
      for (int u = 0; u < NU; u++)
         chk("drain", u, 8'(exp_q[u].size()), 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
